// File: rtl/ws2812_stream_driver.sv
// WS2812 serial driver: streams pixel words MSB-first with a one-deep prefetch buffer.
// Optional WS2812_UNDERRUN_ABORT_EN: abort the frame (with an underrun pulse) instead of zero-filling.
module ws2812_stream_driver #(
    parameter int NUM_LEDS     = 60,
    parameter int BITS_PER_LED = 24,
    parameter int T0H          = 8,
    parameter int T1H          = 16,
    parameter int TBIT         = 25,
    parameter int TRES         = 2048
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    led,
    output logic                    busy,
    output logic                    frame_done,
`ifdef WS2812_UNDERRUN_ABORT_EN
    output logic                    underrun,
`endif
    output logic [1:0]              dbg_state
);

    localparam int CMAX = (TBIT > TRES) ? TBIT : TRES;
    localparam int CW   = $clog2(CMAX);
    localparam int BW   = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam int PW   = $clog2(NUM_LEDS + 1);
    localparam logic [CW-1:0] T0H_C  = CW'(T0H);
    localparam logic [CW-1:0] T1H_C  = CW'(T1H);
    localparam logic [CW-1:0] TBIT_M = CW'(TBIT - 1);
    localparam logic [CW-1:0] TRES_M = CW'(TRES - 1);
    localparam logic [BW-1:0] BIT_M  = BW'(BITS_PER_LED - 1);
    localparam logic [PW-1:0] PIX_M  = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] PIX_N  = PW'(NUM_LEDS);

    typedef enum logic [1:0] {IDLE, PRIME, SEND, LATCH} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [BW-1:0]           bit_idx, bit_n;
    logic [PW-1:0]           pix_idx, pix_n;
    logic [PW-1:0]           acc;
    logic [BITS_PER_LED-1:0] shreg, sh_n, hold;
    logic                    hold_full;
    logic                    xfer, bit_end, pix_end, last_pix, reload, fill;
`ifdef WS2812_UNDERRUN_ABORT_EN
    logic                    abort;
`endif

    // Handshake: a pixel moves when pix_valid && pix_ready at a rising edge; pix_ready is
    // high while a slot in the frame is still unassigned and the holding register is empty.
    assign pix_ready = ((state == PRIME) || (state == SEND)) && !hold_full && (acc < PIX_N);
    assign xfer      = pix_valid && pix_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign bit_end   = (cnt == TBIT_M);
    assign pix_end   = bit_end && (bit_idx == BIT_M);
    assign last_pix  = (pix_idx == PIX_M);
    assign reload    = (state == SEND) && pix_end && !last_pix;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        pix_n   = pix_idx;
        sh_n    = shreg;
        fill    = 1'b0;
`ifdef WS2812_UNDERRUN_ABORT_EN
        abort   = 1'b0;
`endif
        case (state)
            IDLE: if (start) state_n = PRIME;
            PRIME: begin
                if (xfer) begin
                    state_n = SEND;
                    cnt_n   = '0;
                    bit_n   = '0;
                    pix_n   = '0;
                    sh_n    = pix_data;
                end
            end
            SEND: begin
                if (!bit_end) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (!pix_end) begin
                        bit_n = bit_idx + 1'b1;
                        sh_n  = shreg << 1;
                    end else if (last_pix) begin
                        state_n = LATCH;
                    end else begin
                        bit_n = '0;
                        pix_n = pix_idx + 1'b1;
                        // A pixel arriving exactly at the reload edge bypasses the holding register.
                        if (hold_full)  sh_n = hold;
                        else if (xfer)  sh_n = pix_data;
                        else begin
`ifdef WS2812_UNDERRUN_ABORT_EN
                            abort   = 1'b1;
                            state_n = LATCH;
`else
                            sh_n = '0;
                            fill = 1'b1;
`endif
                        end
                    end
                end
            end
            LATCH: begin
                if (cnt == TRES_M) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            pix_idx    <= '0;
            acc        <= '0;
            shreg      <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            led        <= 1'b0;
            frame_done <= 1'b0;
`ifdef WS2812_UNDERRUN_ABORT_EN
            underrun   <= 1'b0;
`endif
        end else begin
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            pix_idx    <= pix_n;
            shreg      <= sh_n;
            // led is the level for the counter position being entered.
            led        <= (state_n == SEND) &&
                          (cnt_n < (sh_n[BITS_PER_LED-1] ? T1H_C : T0H_C));
            frame_done <= (state == LATCH) && (state_n == IDLE);
`ifdef WS2812_UNDERRUN_ABORT_EN
            underrun   <= abort;
`endif
            if (state == IDLE)      acc <= '0;
            else if (xfer || fill)  acc <= acc + 1'b1;
            if ((state == SEND) && xfer && !reload) begin
                hold      <= pix_data;
                hold_full <= 1'b1;
            end else if (reload && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Bench for ws2812_stream_driver: default 24-bit instance and a 32-bit RGBW instance,
// each checked cycle by cycle against a waveform computed from pixel words and timing rules.
module tb_ws2812_stream_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        pv_a = 1'b0, pv_b = 1'b0;
    logic [31:0] pdata = '0;
    logic        rdy_a, led_a, busy_a, fd_a, un_a;
    logic        rdy_b, led_b, busy_b, fd_b, un_b;
    logic [1:0]  dbg_a, dbg_b;

    logic [4:0]  exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          sel     = 0;
    int          cyc_idx = 0;

    always #5 clk = ~clk;

    ws2812_stream_driver #(.NUM_LEDS(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pix_data(pdata[23:0]),
        .pix_valid(pv_a), .pix_ready(rdy_a), .led(led_a), .busy(busy_a),
        .frame_done(fd_a),
`ifdef WS2812_UNDERRUN_ABORT_EN
        .underrun(un_a),
`endif
        .dbg_state(dbg_a)
    );

    ws2812_stream_driver #(.NUM_LEDS(2), .BITS_PER_LED(32), .T0H(6), .T1H(12),
                           .TBIT(20), .TRES(100)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pix_data(pdata),
        .pix_valid(pv_b), .pix_ready(rdy_b), .led(led_b), .busy(busy_b),
        .frame_done(fd_b),
`ifdef WS2812_UNDERRUN_ABORT_EN
        .underrun(un_b),
`endif
        .dbg_state(dbg_b)
    );

`ifndef WS2812_UNDERRUN_ABORT_EN
    assign un_a = 1'b0;
    assign un_b = 1'b0;
`endif

    // Expected entry layout: {led, busy, frame_done, pix_ready, underrun}
    always @(negedge clk) begin
        logic [4:0] e, o;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (sel == 0) ? {led_a, busy_a, fd_a, rdy_a, un_a}
                           : {led_b, busy_b, fd_b, rdy_b, un_b};
            n_tests++;
            if (o !== e) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("[TB] FAIL cycle_check dut=%0d cyc=%0d led/busy/done/ready/underrun got %b want %b",
                             sel, cyc_idx, o, e);
            end
            cyc_idx++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic void get_cfg(input int s, output int b, output int t, output int t0,
                                    output int t1, output int tr);
        if (s == 0) begin b = 24; t = 25; t0 = 8; t1 = 16; tr = 2048; end
        else        begin b = 32; t = 20; t0 = 6; t1 = 12; tr = 100;  end
    endfunction

    // Level of the serial line at a given cycle offset from the first bit of the frame.
    function automatic logic model_led(input logic [31:0] w0, input logic [31:0] w1, input int off,
                                       input int b, input int t, input int t0, input int t1);
        int per, pix, bi, hi;
        logic [31:0] word;
        per  = off / t;
        pix  = per / b;
        bi   = b - 1 - (per % b);
        word = (pix == 0) ? w0 : w1;
        hi   = word[bi] ? t1 : t0;
        return (off % t) < hi;
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_valid(input int s, input logic v);
        if (s == 0) pv_a = v; else pv_b = v;
    endtask

    // w: extra PRIME cycles before pixel 0 is offered; o: offset from the first bit at
    // which pixel 1 is offered (later than the last cycle of pixel 0 means underrun).
    task automatic run_frame(input int s, input logic [31:0] p0, input logic [31:0] p1,
                             input int w, input int o, input bit early, output int span);
        int b, t, t0, t1, tr, r, sl, f, l;
        bit late, abort, hs;
        logic [31:0] s1;
        get_cfg(s, b, t, t0, t1, tr);
        r     = b * t - 1;
        late  = (o > r);
        abort = 1'b0;
`ifdef WS2812_UNDERRUN_ABORT_EN
        abort = late;
`endif
        sl    = abort ? b * t : 2 * b * t;
        s1    = late ? 32'd0 : p1;
        span  = sl + tr;
        f     = 2 + w + sl + tr;
        l     = f + 3;
        sel   = s;
        cyc_idx = 0;
        @(posedge clk); #1;
        exp_q.push_back(5'b00000);
        for (int i = 0; i <= w; i++) exp_q.push_back(5'b01010);
        for (int i = 0; i < sl; i++)
            exp_q.push_back({model_led(p0, s1, i, b, t, t0, t1), 1'b1, 1'b0,
                             (i <= o) && (i <= r), 1'b0});
        for (int i = 0; i < tr; i++) exp_q.push_back({4'b0100, abort && (i == 0)});
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00000);
        hs = 1'b0;
        for (int k = 0; k < l; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (hs) set_valid(s, 1'b0);
            set_start(s, (k == 0) || ((k < f) && ($urandom_range(0, 15) == 0)));
            if ((k == 1 + w) || (early && (w == 0) && (k == 0))) begin
                pdata = p0;
                set_valid(s, 1'b1);
            end
            if (k == 2 + w + o) begin
                pdata = p1;
                set_valid(s, 1'b1);
            end
            @(negedge clk);
            hs = (s == 0) ? (pv_a && rdy_a) : (pv_b && rdy_b);
        end
        set_valid(s, 1'b0);
        set_start(s, 1'b0);
    endtask

    task automatic reset_midframe();
        sel = 0;
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; pdata = 32'hFFFFFF; pv_a = 1'b1;
        @(posedge clk); #1; pv_a = 1'b0;
        repeat (253) @(posedge clk);
        #1;
        check("pre_reset_led", led_a, 1);
        check("pre_reset_busy", busy_a, 1);
        #2 reset = 1'b0;
        #1;
        check("reset_led", led_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_ready", rdy_a, 0);
        check("reset_done", fd_a, 0);
        @(posedge clk); #1; reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_reset_idle_busy", busy_a, 0);
        check("post_reset_idle_led", led_a, 0);
    endtask

    initial begin
        int span, cnt, w, o, r;
        int wid[8];
        logic [31:0] p0, p1;
        wid = '{16, 8, 16, 8, 8, 16, 8, 16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led_a", led_a, 0);
        check("rst_ready_a", rdy_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", fd_a, 0);
        check("rst_underrun_a", un_a, 0);
        check("rst_led_b", led_b, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_ready_b", rdy_b, 0);
        @(posedge clk); #1; reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_after_release_busy", busy_a, 0);
        check("idle_after_release_led", led_a, 0);

        for (int p = 0; p < 8; p++) begin
            cnt = 0;
            for (int c = 0; c < 25; c++) cnt += model_led(32'hA50000, 32'h0, p * 25 + c, 24, 25, 8, 16);
            check("model_width_a50000", cnt, wid[p]);
        end
        cnt = 0;
        for (int c = 0; c < 25; c++) cnt += model_led(32'hFFFFFF, 32'h0, c, 24, 25, 8, 16);
        check("model_width_ones", cnt, 16);
        cnt = 0;
        for (int c = 0; c < 25; c++) cnt += model_led(32'hFFFFFF, 32'h0, 24 * 25 + c, 24, 25, 8, 16);
        check("model_width_zeros", cnt, 8);

        run_frame(0, 32'hFFFFFF, 32'h000000, 0, 0, 1'b0, span);
        check("frame_span_a", span, 3248);
        run_frame(0, 32'hA50000, {8'h0, 24'($urandom)}, $urandom_range(0, 5), $urandom_range(0, 599), 1'b1, span);
        run_frame(0, {8'h0, 24'($urandom)}, {8'h0, 24'($urandom)}, 100, $urandom_range(0, 599), 1'b0, span);
        run_frame(0, {8'h0, 24'($urandom)}, {8'h0, 24'($urandom)}, 0, 599, 1'b0, span);
        run_frame(0, {8'h0, 24'($urandom)}, 32'hFFFFFF, 1, 600, 1'b0, span);
        run_frame(0, {8'h0, 24'($urandom)}, 32'hFFFFFF, 2, 5000, 1'b0, span);
        r = 599;
        for (int n = 0; n < 5; n++) begin
            p0 = {8'h0, 24'($urandom)};
            p1 = {8'h0, 24'($urandom)};
            w  = $urandom_range(0, 10);
            o  = ($urandom_range(0, 3) == 0) ? $urandom_range(r + 1, 2 * r) : $urandom_range(0, r);
            run_frame(0, p0, p1, w, o, 1'($urandom_range(0, 1)), span);
        end
        reset_midframe();
        run_frame(0, {8'h0, 24'($urandom)}, {8'h0, 24'($urandom)}, 0, $urandom_range(0, 599), 1'b0, span);

        run_frame(1, $urandom, $urandom, 0, $urandom_range(0, 639), 1'b0, span);
        check("frame_span_b", span, 1380);
        run_frame(1, $urandom, $urandom, 3, 639, 1'b0, span);
        run_frame(1, $urandom, $urandom, 1, 640, 1'b0, span);
        for (int n = 0; n < 2; n++)
            run_frame(1, $urandom, $urandom, $urandom_range(0, 8), $urandom_range(0, 700), 1'b1, span);

        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_stream_driver.md
WS2812_STREAM_DRIVER -- requirements
Module: ws2812_stream_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 60, meaning pixels per frame (>=1).
REQ-002 SHALL have parameter BITS_PER_LED, default 24, meaning pixel width (24 = RGB, 32 = RGBW).
REQ-003 SHALL have parameter T0H, default 8, meaning high cycles for a 0 bit.
REQ-004 SHALL have parameter T1H, default 16, meaning high cycles for a 1 bit.
REQ-005 SHALL have parameter TBIT, default 25, meaning cycles per bit period.
REQ-006 SHALL have parameter TRES, default 2048, meaning latch (low) cycles after a frame.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (low = asserted).
REQ-009 SHALL have port start, input, 1 bit: frame request, sampled in IDLE only.
REQ-010 SHALL have port pix_data, input, BITS_PER_LED bits: pixel word, MSB transmitted first.
REQ-011 SHALL have port pix_valid, input, 1 bit: pix_data valid.
REQ-012 SHALL have port pix_ready, output, 1 bit: holding register empty; transfer when pix_valid and pix_ready are both high on a clock edge.
REQ-013 SHALL have port led, output, 1 bit: registered serial line to the LED chain.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of latch.

Function
REQ-016 SHALL implement states IDLE, PRIME, SEND, LATCH.
REQ-017 IDLE: start high -> PRIME next cycle. start SHALL be ignored in every other state.
REQ-018 PRIME: pix_ready high; wait indefinitely for the first pixel. On transfer, SEND begins the next cycle with bit period count 0.
REQ-019 SEND: bit counter runs 0..TBIT-1 and wraps. led SHALL be high for exactly T0H (bit=0) or T1H (bit=1) cycles, then low for the rest of the period.
REQ-020 Bit periods SHALL be back-to-back with no gap, including across pixel boundaries.
REQ-021 SHALL use a shift register plus one holding register. The shift register reloads from the holding register at count 0 of each pixel's first bit. pix_ready SHALL stay high whenever the holding register is empty, so the next pixel can be prefetched.
REQ-022 SHALL count pixels 0..NUM_LEDS-1. No more than NUM_LEDS pixels are accepted per frame. pix_ready SHALL be low once the last pixel is loaded.
REQ-023 After the last period of the last bit, SHALL enter LATCH with led low for exactly TRES cycles. frame_done then pulses for 1 cycle concurrent with return to IDLE.
REQ-024 Underrun: holding register empty at a pixel reload point (not the first pixel); handling per REQ-030/031.
REQ-025 Counter widths SHALL be sized from the parameters (ceiling log2). Parameter constraint: 0 < T0H < T1H < TBIT.

Reset
REQ-026 While reset is low, outputs SHALL be: led=0, pix_ready=0, busy=0, frame_done=0, underrun=0; state=IDLE; all counters and the holding register cleared.
REQ-027 Reset asserted mid-frame SHALL force led low asynchronously and discard all buffered pixels. No frame_done is issued.
REQ-028 After reset deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-029 SHALL use macro WS2812_UNDERRUN_ABORT_EN.
REQ-030 Macro defined: adds output port underrun (1 bit). On underrun, pulse underrun for 1 cycle, abort the frame, enter LATCH (led low), and complete via REQ-023.
REQ-031 Macro undefined: no underrun port. On underrun, transmit an all-zero pixel in its place, count it toward NUM_LEDS, and continue without gap.

Verification
REQ-032 NUM_LEDS=2, 24b, pixels 0xFFFFFF and 0x000000 always valid -> 24 periods of 16H/9L, then 24 of 8H/17L, 2048 low, frame_done once; total 3248 cycles from first SEND cycle.
REQ-033 pixel 0xA50000 -> first 8 periods high widths 16,8,16,8,8,16,8,16.
REQ-034 pix_valid held low 100 cycles after start -> led low, busy high, pix_ready high; first high edge 1 cycle after transfer.
REQ-035 2nd pixel withheld past reload -> with macro: underrun pulse, led low TRES, frame_done; without: 24 periods of 8H, frame continues.
REQ-036 reset low at bit 10 of pixel 0 -> led 0 same cycle, busy 0; start after release -> fresh frame from pixel 0.
REQ-037 BITS_PER_LED=32, T0H=6, T1H=12, TBIT=20, TRES=100 -> 32 periods of 20 cycles per pixel, 100-cycle latch.
